// File: rtl/mips32_prog_loader.sv
// Host-side program loader and register dumper for the MIPS32 core.
// Streams a program into instruction memory, runs the core, then dumps registers.
module mips32_prog_loader #(
   parameter int ADDR_W = 10,
   parameter int NREGS  = 32
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [31:0]       s_data,
   input  logic              s_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              core_start,
   input  logic              core_halted,
   input  logic              dump_en,
   output logic [4:0]        reg_raddr,
   input  logic [31:0]       reg_rdata,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [31:0]       m_data,
   output logic              m_last,
   input  logic              restart,
   output logic              ovf
);

   typedef enum logic [2:0] {
      LOAD, START, RUN, DUMP, DONE
   } state_t;

   localparam logic [ADDR_W-1:0] WR_MAX = '1;
   localparam logic [4:0] RD_MAX = 5'(NREGS - 1);

   state_t state, state_nx;
   logic [ADDR_W-1:0] wr_ptr;
   logic [4:0] rd_ptr;
   logic s_acc, m_acc;
   logic wr_full, rd_end;

   assign s_acc   = s_valid && (state == LOAD);
   assign m_acc   = m_ready && (state == DUMP);
   assign wr_full = (wr_ptr == WR_MAX);
   assign rd_end  = (rd_ptr == RD_MAX);

   assign reg_raddr = rd_ptr;
   assign m_data    = reg_rdata;

   always_comb begin
      state_nx   = state;
      s_ready    = 1'b0;
      core_hold  = 1'b1;
      core_start = 1'b0;
      m_valid    = 1'b0;
      m_last     = 1'b0;
      unique case (state)
         LOAD: begin
            s_ready = 1'b1;
            if (s_acc && (s_last || wr_full))
               state_nx = START;
         end
         START: begin
            core_start = 1'b1;
            core_hold  = 1'b0;
            state_nx   = RUN;
         end
         RUN: begin
            core_hold = 1'b0;
            if (core_halted)
               state_nx = dump_en ? DUMP : DONE;
         end
         DUMP: begin
            m_valid = 1'b1;
            m_last  = rd_end;
            if (m_acc && rd_end)
               state_nx = DONE;
         end
         DONE: begin
            if (restart)
               state_nx = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ovf       <= 1'b0;
      end else begin
         state  <= state_nx;
         mem_we <= s_acc;
         if (s_acc) begin
            mem_addr  <= wr_ptr;
            mem_wdata <= s_data;
            if (!wr_full)
               wr_ptr <= wr_ptr + 1'b1;
            // capacity reached before the program ended
            if (wr_full && !s_last)
               ovf <= 1'b1;
         end
         if (state == RUN && core_halted)
            rd_ptr <= '0;
         if (m_acc && !rd_end)
            rd_ptr <= rd_ptr + 1'b1;
         if (state == DONE && restart) begin
            wr_ptr <= '0;
            ovf    <= 1'b0;
         end
      end
   end

endmodule
